iob_sram_mp: RTL and testbench

Multi-port shared SRAM for the SoC: N_PORTS IOb-native request ports arbitrate onto a single byte-enabled single-port RAM, replacing the fixed two-port instruction/data memory. One request is served per cycle. Arbitration is round-robin by default and fixed-priority when configured. Each port gets its own rvalid and held read-data. It sits between the CPU/DMA/boot-loader buses and main memory.

---
 rtl/iob_sram_mp.sv | 142 ++++++++++++++
 tb/tb_iob_sram_mp.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_sram_mp.sv
// rtl/iob_sram_mp.sv - multi-port shared byte-enabled SRAM with round-robin or fixed-priority arbitration (IOB_SRAM_MP_FIXED_PRIO_EN)
module iob_sram_mp #(
    parameter int    N_PORTS = 2,
    parameter int    DATA_W  = 32,
    parameter int    ADDR_W  = 12,
    parameter string HEXFILE = "none"
) (
    input  logic                        clk_i,
    input  logic                        arst_n_i,
    input  logic                        cke_i,
    input  logic [N_PORTS-1:0]          avalid_i,
    input  logic [N_PORTS*ADDR_W-1:0]   addr_i,
    input  logic [N_PORTS*DATA_W-1:0]   wdata_i,
    input  logic [N_PORTS*DATA_W/8-1:0] wstrb_i,
    output logic [N_PORTS-1:0]          ready_o,
    output logic [N_PORTS-1:0]          rvalid_o,
    output logic [N_PORTS*DATA_W-1:0]   rdata_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic [PTR_W-1:0]   gnt;
    logic               gnt_any;
    logic               acc;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [STRB_W-1:0]  sel_strb;
    logic               is_write;
    logic               rd_acc;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  ram_q;
    logic [N_PORTS-1:0] pend;
    logic [DATA_W-1:0]  hold [N_PORTS];

    generate
        if (N_PORTS == 1) begin : g_single
            assign gnt     = '0;
            assign gnt_any = avalid_i[0];
            assign ready_o = cke_i & arst_n_i;
        end else begin : g_multi
`ifdef IOB_SRAM_MP_FIXED_PRIO_EN
            // lowest-numbered requesting port wins
            always_comb begin
                gnt     = '0;
                gnt_any = 1'b0;
                for (int i = N_PORTS - 1; i >= 0; i--) begin
                    if (avalid_i[i]) begin
                        gnt     = PTR_W'(i);
                        gnt_any = 1'b1;
                    end
                end
            end
`else
            logic [PTR_W-1:0] ptr;

            // first requester found scanning upward from ptr, wrapping
            always_comb begin
                int idx;
                idx     = 0;
                gnt     = '0;
                gnt_any = 1'b0;
                for (int i = 0; i < N_PORTS; i++) begin
                    idx = (int'(ptr) + i) % N_PORTS;
                    if (!gnt_any && avalid_i[idx]) begin
                        gnt     = PTR_W'(idx);
                        gnt_any = 1'b1;
                    end
                end
            end

            // pointer moves past the winner; holds when idle or stalled
            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i) begin
                    ptr <= '0;
                end else if (cke_i && gnt_any) begin
                    ptr <= PTR_W'((int'(gnt) + 1) % N_PORTS);
                end
            end
`endif
            // one-hot grant, suppressed while stalled or in reset
            always_comb begin
                ready_o = '0;
                if (cke_i && arst_n_i && gnt_any) begin
                    ready_o[gnt] = 1'b1;
                end
            end
        end
    endgenerate

    assign acc       = cke_i & arst_n_i & gnt_any;
    assign sel_addr  = addr_i[int'(gnt)*ADDR_W +: ADDR_W];
    assign sel_wdata = wdata_i[int'(gnt)*DATA_W +: DATA_W];
    assign sel_strb  = wstrb_i[int'(gnt)*STRB_W +: STRB_W];
    assign is_write  = |sel_strb;
    assign rd_acc    = acc & ~is_write;

    // single-port RAM: byte-masked write, registered read
    always_ff @(posedge clk_i) begin
        if (acc) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (sel_strb[b]) begin
                    mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
            if (!is_write) begin
                ram_q <= mem[sel_addr];
            end
        end
    end

    // read tracking and per-port held read data, all frozen while cke_i is low
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            pend <= '0;
            for (int k = 0; k < N_PORTS; k++) begin
                hold[k] <= '0;
            end
        end else if (cke_i) begin
            for (int k = 0; k < N_PORTS; k++) begin
                if (pend[k]) begin
                    hold[k] <= ram_q;
                end
            end
            pend <= rd_acc ? (N_PORTS'(1) << gnt) : '0;
        end
    end

    // a pending read completes only in an enabled cycle
    assign rvalid_o = pend & {N_PORTS{cke_i}};

    // live RAM data on the completing cycle, held copy otherwise
    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            rdata_o[k*DATA_W +: DATA_W] = rvalid_o[k] ? ram_q : hold[k];
        end
    end

endmodule

// File: tb/tb_iob_sram_mp.sv
// tb/tb_iob_sram_mp.sv - self-checking bench for iob_sram_mp
module tb_iob_sram_mp;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cke;
    logic [N-1:0]    avalid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N*SW-1:0] wstrb;
    logic [N-1:0]    ready;
    logic [N-1:0]    rvalid;
    logic [N*DW-1:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iob_sram_mp #(
        .N_PORTS(N),
        .DATA_W (DW),
        .ADDR_W (AW),
        .HEXFILE("none")
    ) dut (
        .clk_i   (clk),
        .arst_n_i(rst_n),
        .cke_i   (cke),
        .avalid_i(avalid),
        .addr_i  (addr),
        .wdata_i (wdata),
        .wstrb_i (wstrb),
        .ready_o (ready),
        .rvalid_o(rvalid),
        .rdata_o (rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // behavioural model: arbitration by scan, memory as associative array,
    // one outstanding completion per cycle
    int          m_ptr;
    int          m_pend;
    logic [31:0] m_pdata;
    logic [31:0] m_hold [N];
    logic [31:0] m_mem [int];

    always @(negedge clk) begin
        int          g;
        int          a;
        logic [3:0]  s;
        logic [31:0] w;
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_rv;
        logic [31:0] e_d;
        if (!rst_n) begin
            m_ptr  = 0;
            m_pend = -1;
            for (int k = 0; k < N; k++) m_hold[k] = '0;
            chk("rst_ready", 32'(ready), 32'd0);
            chk("rst_rvalid", 32'(rvalid), 32'd0);
            for (int k = 0; k < N; k++) chk("rst_rdata", rdata[k*DW +: DW], 32'd0);
        end else begin
            g = -1;
            if (cke) begin
                for (int i = 0; i < N; i++) begin
                    int idx;
`ifdef IOB_SRAM_MP_FIXED_PRIO_EN
                    idx = i;
`else
                    idx = (m_ptr + i) % N;
`endif
                    if (g < 0 && avalid[idx]) g = idx;
                end
            end
            e_rdy = '0;
            if (g >= 0) e_rdy[g] = 1'b1;
            e_rv = '0;
            if (cke && m_pend >= 0) e_rv[m_pend] = 1'b1;
            chk("ready", 32'(ready), 32'(e_rdy));
            chk("rvalid", 32'(rvalid), 32'(e_rv));
            for (int k = 0; k < N; k++) begin
                e_d = e_rv[k] ? m_pdata : m_hold[k];
                chk("rdata", rdata[k*DW +: DW], e_d);
            end
            if (cke) begin
                if (m_pend >= 0) m_hold[m_pend] = m_pdata;
                m_pend = -1;
                if (g >= 0) begin
`ifndef IOB_SRAM_MP_FIXED_PRIO_EN
                    m_ptr = (g + 1) % N;
`endif
                    a = int'(addr[g*AW +: AW]);
                    s = wstrb[g*SW +: SW];
                    if (s == 4'd0) begin
                        m_pend  = g;
                        m_pdata = m_mem.exists(a) ? m_mem[a] : 32'd0;
                    end else begin
                        w = m_mem.exists(a) ? m_mem[a] : 32'd0;
                        for (int b = 0; b < SW; b++)
                            if (s[b]) w[b*8 +: 8] = wdata[g*DW + b*8 +: 8];
                        m_mem[a] = w;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // present a request and hold it until accepted; returns in the cycle after acceptance
    task automatic req(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        avalid[p] = 1'b1;
        addr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
        wstrb[p*SW +: SW] = s;
        @(negedge clk);
        while (!ready[p] && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("req_accept", 32'(ready[p]), 32'd1);
        @(posedge clk);
        #1;
        avalid[p] = 1'b0;
    endtask

    int gseq [6];
    int gi;

    initial begin
        rst_n  = 1'b0;
        cke    = 1'b1;
        avalid = '0;
        addr   = '0;
        wdata  = '0;
        wstrb  = '0;
        avalid[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_during_reset", 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        avalid = '0;
        rst_n  = 1'b1;
        cyc(1);

        // write then read on port 0
        req(0, 6'd5, 32'hDEADBEEF, 4'hF);
        req(0, 6'd5, 32'd0, 4'h0);
        @(negedge clk);
        chk("t1_rvalid", 32'(rvalid), 32'h1);
        chk("t1_rdata", rdata[31:0], 32'hDEADBEEF);
        cyc(3);
        @(negedge clk);
        chk("t1_rvalid_after", 32'(rvalid), 32'h0);
        chk("t1_rdata_held", rdata[31:0], 32'hDEADBEEF);
        cyc(1);

        // byte strobes on port 1
        req(1, 6'd7, 32'h11223344, 4'hF);
        req(1, 6'd7, 32'hAABBCCDD, 4'b0101);
        req(1, 6'd7, 32'd0, 4'h0);
        @(negedge clk);
        chk("t2_rdata", rdata[63:32], 32'h11BB33DD);
        cyc(1);

        // preload, reset pointer, then all ports read continuously
        req(0, 6'd1, 32'h000000A1, 4'hF);
        req(0, 6'd2, 32'h000000A2, 4'hF);
        req(0, 6'd3, 32'h000000A3, 4'hF);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        for (int p = 0; p < N; p++) begin
            addr[p*AW +: AW] = AW'(p + 1);
            wstrb[p*SW +: SW] = 4'h0;
        end
        avalid = '1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            gi = -1;
            for (int k = 0; k < N; k++) if (ready[k]) gi = k;
            gseq[i] = gi;
            if (i < 5) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        avalid = '0;
        for (int i = 0; i < 6; i++) begin
`ifdef IOB_SRAM_MP_FIXED_PRIO_EN
            chk("rr_grant", 32'(gseq[i]), 32'd0);
`else
            chk("rr_grant", 32'(gseq[i]), 32'(i % 3));
`endif
        end
        cyc(2);
        @(negedge clk);
        chk("rr_hold0", rdata[31:0], 32'h000000A1);
`ifdef IOB_SRAM_MP_FIXED_PRIO_EN
        chk("rr_hold1", rdata[63:32], 32'h0);
        chk("rr_hold2", rdata[95:64], 32'h0);
`else
        chk("rr_hold1", rdata[63:32], 32'h000000A2);
        chk("rr_hold2", rdata[95:64], 32'h000000A3);
`endif
        cyc(1);

        // clock-enable stall with a pending read on port 1
        req(1, 6'd2, 32'd0, 4'h0);
        cke = 1'b0;
        avalid[0] = 1'b1;
        addr[0 +: AW] = 6'd1;
        wstrb[0 +: SW] = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rvalid1", 32'(rvalid[1]), 32'd0);
            chk("stall_ready", 32'(ready), 32'd0);
            @(posedge clk);
            #1;
        end
        cke = 1'b1;
        avalid[0] = 1'b0;
        @(negedge clk);
        chk("stall_release_rvalid", 32'(rvalid), 32'h2);
        chk("stall_release_rdata", rdata[63:32], 32'h000000A2);
        cyc(2);

        // reset in the cycle after a read acceptance
        req(0, 6'd5, 32'd0, 4'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_rvalid", 32'(rvalid), 32'd0);
            for (int k = 0; k < N; k++) chk("post_rst_rdata", rdata[k*DW +: DW], 32'd0);
        end
        @(posedge clk);
        #1;
        addr[0 +: AW]   = 6'd5;
        wstrb[0 +: SW]  = 4'h0;
        addr[AW +: AW]  = 6'd7;
        wstrb[SW +: SW] = 4'h0;
        avalid = 3'b011;
        @(negedge clk);
        chk("post_rst_grant", 32'(ready), 32'h1);
        @(posedge clk);
        #1;
        avalid[0] = 1'b0;
        @(negedge clk);
        chk("post_rst_rvalid0", 32'(rvalid), 32'h1);
        chk("post_rst_mem5", rdata[31:0], 32'hDEADBEEF);
        @(posedge clk);
        #1;
        avalid[1] = 1'b0;
        @(negedge clk);
        chk("post_rst_rvalid1", 32'(rvalid), 32'h2);
        chk("post_rst_mem7", rdata[63:32], 32'h11BB33DD);
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
